// File: rtl/chess_move_controller.sv
// chess_move_controller
//
// Sequencing controller for the chess board datapath. It moves the on-board
// cursor, latches a source square, and asks the move generator for a
// legal-destination mask. It then takes a destination and commits the move
// with two board writes: the destination square first, then the cleared source.
// Side-to-move toggles when the move completes. After reset this block
// performs every board write.
//
// Optional feature macro: CHESS_PROMOTE_EN. When it is defined, a pawn that
// reaches its far rank is written as a queen of the same colour.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   cursor     {up, down, left, right} level buttons
//   select     select level button
//   brdAddr    board square address {row, col}
//   brdRdata   board read data (1-cycle synchronous read latency)
//   brdWe      board write enable
//   brdWdata   board write data
//   genReq     move-generator request, held until genDone
//   genSq      source square for the generator
//   genDone    generator completion pulse
//   genMask    legal destination mask, valid on the genDone cycle
//   cursorRow  cursor row, for display
//   cursorCol  cursor column, for display
//   turn       side to move (0 = white)
//   srcValid   a source square is latched
//   srcSq      latched source square
//   moveDone   1-cycle pulse when a move is committed
//   capture    destination contents overwritten by the last committed move
//   error      1-cycle pulse on a rejected select or a generator timeout

module chess_move_controller #(
    parameter int unsigned GEN_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cursor,
    input  logic        select,
    output logic [5:0]  brdAddr,
    input  logic [4:0]  brdRdata,
    output logic        brdWe,
    output logic [4:0]  brdWdata,
    output logic        genReq,
    output logic [5:0]  genSq,
    input  logic        genDone,
    input  logic [63:0] genMask,
    output logic [2:0]  cursorRow,
    output logic [2:0]  cursorCol,
    output logic        turn,
    output logic        srcValid,
    output logic [5:0]  srcSq,
    output logic        moveDone,
    output logic [4:0]  capture,
    output logic        error
);

    typedef enum logic [2:0] {
        PICK_SRC,
        RD_SRC,
        GEN,
        PICK_DST,
        RD_DST,
        WR_DST,
        WR_SRC
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(GEN_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cursor_prev_q, cursor_prev_d;
    logic        select_prev_q, select_prev_d;
    logic        armed_q, armed_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        turn_q, turn_d;
    logic        src_valid_q, src_valid_d;
    logic [5:0]  src_sq_q, src_sq_d;
    logic [5:0]  dst_sq_q, dst_sq_d;
    logic [4:0]  piece_q, piece_d;
    logic [63:0] mask_q, mask_d;
    logic [4:0]  capture_q, capture_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        rd_wait_q, rd_wait_d;

    logic [3:0]  cursor_edge;
    logic        select_edge;
    logic [5:0]  cursor_sq;
    logic        move_en;
    logic [4:0]  wr_piece;
    logic [5:0]  addr;
    logic        we;
    logic [4:0]  wdata;
    logic        gen_req;
    logic        move_done;
    logic        err;

    // Piece written to the destination square; optionally promotes pawns.
    always_comb begin
        wr_piece = piece_q;
`ifdef CHESS_PROMOTE_EN
        if (piece_q[4:2] == 3'b001 &&
            ((!piece_q[1] && dst_sq_q[5:3] == 3'd0) ||
             ( piece_q[1] && dst_sq_q[5:3] == 3'd7))) begin
            wr_piece = {3'b101, piece_q[1], 1'b1};
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        cursor_prev_d = cursor;
        select_prev_d = select;
        armed_d       = 1'b1;
        row_d         = row_q;
        col_d         = col_q;
        turn_d        = turn_q;
        src_valid_d   = src_valid_q;
        src_sq_d      = src_sq_q;
        dst_sq_d      = dst_sq_q;
        piece_d       = piece_q;
        mask_d        = mask_q;
        capture_d     = capture_q;
        tmo_cnt_d     = tmo_cnt_q;
        rd_wait_d     = rd_wait_q;

        addr      = {row_q, col_q};
        we        = 1'b0;
        wdata     = '0;
        gen_req   = 1'b0;
        move_done = 1'b0;
        err       = 1'b0;

        // Edges are masked for the first cycle after reset. This lets the
        // prev registers pick up buttons that were held through reset.
        cursor_edge = armed_q ? (cursor & ~cursor_prev_q) : '0;
        select_edge = armed_q & select & ~select_prev_q;
        cursor_sq   = {row_q, col_q};
        move_en     = (state_q == PICK_SRC) || (state_q == PICK_DST);

        // Priority picks one direction per cycle, even when that move clamps.
        if (move_en) begin
            if (cursor_edge[3]) begin
                if (row_q != 3'd0) row_d = row_q - 3'd1;
            end else if (cursor_edge[2]) begin
                if (row_q != 3'd7) row_d = row_q + 3'd1;
            end else if (cursor_edge[1]) begin
                if (col_q != 3'd0) col_d = col_q - 3'd1;
            end else if (cursor_edge[0]) begin
                if (col_q != 3'd7) col_d = col_q + 3'd1;
            end
        end

        case (state_q)
            PICK_SRC: begin
                if (select_edge) state_d = RD_SRC;
            end
            RD_SRC: begin
                if (brdRdata[0] && (brdRdata[1] == turn_q)) begin
                    src_sq_d    = cursor_sq;
                    piece_d     = brdRdata;
                    src_valid_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = GEN;
                end else begin
                    err     = 1'b1;
                    state_d = PICK_SRC;
                end
            end
            GEN: begin
                gen_req = 1'b1;
                // Done wins over a timeout that expires in the same cycle.
                if (genDone) begin
                    mask_d    = genMask;
                    tmo_cnt_d = '0;
                    state_d   = PICK_DST;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err         = 1'b1;
                    src_valid_d = 1'b0;
                    tmo_cnt_d   = '0;
                    state_d     = PICK_SRC;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            PICK_DST: begin
                if (select_edge) begin
                    if (cursor_sq == src_sq_q) begin
                        src_valid_d = 1'b0;
                        state_d     = PICK_SRC;
                    end else if (mask_q[cursor_sq]) begin
                        dst_sq_d  = cursor_sq;
                        rd_wait_d = 1'b0;
                        state_d   = RD_DST;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            RD_DST: begin
                addr = dst_sq_q;
                // The first cycle issues the read. The second cycle captures it.
                if (!rd_wait_q) begin
                    rd_wait_d = 1'b1;
                end else begin
                    rd_wait_d = 1'b0;
                    capture_d = brdRdata;
                    state_d   = WR_DST;
                end
            end
            WR_DST: begin
                we      = 1'b1;
                addr    = dst_sq_q;
                wdata   = wr_piece;
                state_d = WR_SRC;
            end
            WR_SRC: begin
                we          = 1'b1;
                addr        = src_sq_q;
                wdata       = '0;
                move_done   = 1'b1;
                turn_d      = ~turn_q;
                src_valid_d = 1'b0;
                state_d     = PICK_SRC;
            end
            default: begin
                state_d = PICK_SRC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= PICK_SRC;
            cursor_prev_q <= '0;
            select_prev_q <= 1'b0;
            armed_q       <= 1'b0;
            row_q         <= 3'd6;
            col_q         <= 3'd4;
            turn_q        <= 1'b0;
            src_valid_q   <= 1'b0;
            src_sq_q      <= '0;
            dst_sq_q      <= '0;
            piece_q       <= '0;
            mask_q        <= '0;
            capture_q     <= '0;
            tmo_cnt_q     <= '0;
            rd_wait_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cursor_prev_q <= cursor_prev_d;
            select_prev_q <= select_prev_d;
            armed_q       <= armed_d;
            row_q         <= row_d;
            col_q         <= col_d;
            turn_q        <= turn_d;
            src_valid_q   <= src_valid_d;
            src_sq_q      <= src_sq_d;
            dst_sq_q      <= dst_sq_d;
            piece_q       <= piece_d;
            mask_q        <= mask_d;
            capture_q     <= capture_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rd_wait_q     <= rd_wait_d;
        end
    end

    assign brdAddr   = addr;
    assign brdWe     = we;
    assign brdWdata  = wdata;
    assign genReq    = gen_req;
    assign genSq     = src_sq_q;
    assign cursorRow = row_q;
    assign cursorCol = col_q;
    assign turn      = turn_q;
    assign srcValid  = src_valid_q;
    assign srcSq     = src_sq_q;
    assign moveDone  = move_done;
    assign capture   = capture_q;
    assign error     = err;

endmodule

// File: tb/tb_chess_move_controller.sv
// Directed testbench for chess_move_controller. The bench models the board
// store: a 64 x 5 array with a 1-cycle synchronous read. It drives the move
// generator handshake by hand.

module tb_chess_move_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  cursor;
    logic        select;
    logic [5:0]  brdAddr;
    logic [4:0]  brdRdata;
    logic        brdWe;
    logic [4:0]  brdWdata;
    logic        genReq;
    logic [5:0]  genSq;
    logic        genDone;
    logic [63:0] genMask;
    logic [2:0]  cursorRow;
    logic [2:0]  cursorCol;
    logic        turn;
    logic        srcValid;
    logic [5:0]  srcSq;
    logic        moveDone;
    logic [4:0]  capture;
    logic        error;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int wr_cnt  = 0;
    int err_base;
    int wr_base;

    logic [4:0] mem [64];
    logic [2:0] back [8];
    logic [4:0] promo_exp;

    chess_move_controller #(.GEN_TIMEOUT(255)) dut (
        .clk      (clk),
        .reset    (reset),
        .cursor   (cursor),
        .select   (select),
        .brdAddr  (brdAddr),
        .brdRdata (brdRdata),
        .brdWe    (brdWe),
        .brdWdata (brdWdata),
        .genReq   (genReq),
        .genSq    (genSq),
        .genDone  (genDone),
        .genMask  (genMask),
        .cursorRow(cursorRow),
        .cursorCol(cursorCol),
        .turn     (turn),
        .srcValid (srcValid),
        .srcSq    (srcSq),
        .moveDone (moveDone),
        .capture  (capture),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board store: the read returns the old contents; the write lands after it.
    always @(posedge clk) begin
        brdRdata <= mem[brdAddr];
        if (brdWe) mem[brdAddr] = brdWdata;
    end

    always @(negedge clk) begin
        if (error) err_cnt++;
        if (brdWe) wr_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // b: 3 = up, 2 = down, 1 = left, 0 = right
    task automatic press(input int unsigned b, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cursor[b] = 1'b1;
            step();
            cursor = '0;
            step();
        end
    endtask

    initial begin
        back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int c = 0; c < 8; c++) begin
            mem[c]      = {back[c], 1'b1, 1'b1};
            mem[8 + c]  = 5'b00111;
            mem[48 + c] = 5'b00101;
            mem[56 + c] = {back[c], 1'b0, 1'b1};
        end
`ifdef CHESS_PROMOTE_EN
        promo_exp = 5'b10101;
`else
        promo_exp = 5'b00101;
`endif

        // Reset with "up" held through it.
        reset = 1'b0; cursor = 4'b1000; select = 1'b0; genDone = 1'b0; genMask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row", 64'(cursorRow), 64'd6);
        check("rst_col", 64'(cursorCol), 64'd4);
        check("rst_turn", 64'(turn), 64'd0);
        check("rst_srcvalid", 64'(srcValid), 64'd0);
        check("rst_srcsq", 64'(srcSq), 64'd0);
        check("rst_capture", 64'(capture), 64'd0);
        check("rst_we", 64'(brdWe), 64'd0);
        check("rst_genreq", 64'(genReq), 64'd0);
        check("rst_movedone", 64'(moveDone), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        reset = 1'b1;
        step(); step(); step();
        check("held_through_reset", 64'(cursorRow), 64'd6);
        cursor = '0;
        step();

        // Cursor movement and clamping.
        err_base = err_cnt;
        cursor[3] = 1'b1;
        step();
        check("cursor_latency", 64'(cursorRow), 64'd5);
        cursor = '0;
        step();
        press(3, 9);
        check("clamp_row0", 64'(cursorRow), 64'd0);
        press(1, 10);
        check("clamp_col0", 64'(cursorCol), 64'd0);
        press(2, 10);
        check("clamp_row7", 64'(cursorRow), 64'd7);
        press(0, 10);
        check("clamp_col7", 64'(cursorCol), 64'd7);
        press(3, 1);
        press(1, 3);
        check("back_row", 64'(cursorRow), 64'd6);
        check("back_col", 64'(cursorCol), 64'd4);
        check("no_err_moving", 64'(err_cnt - err_base), 64'd0);

        // Illegal source selections: an empty square (4,4), then the black king (0,4).
        press(3, 2);
        select = 1'b1; step(); select = 1'b0;
        check("empty_err", 64'(error), 64'd1);
        step();
        check("empty_nogen", 64'(genReq), 64'd0);
        check("empty_srcvalid", 64'(srcValid), 64'd0);
        press(3, 4);
        select = 1'b1; step(); select = 1'b0;
        check("black_err", 64'(error), 64'd1);
        step();
        check("black_nogen", 64'(genReq), 64'd0);
        press(2, 6);

        // Legal move e2 -> (5,4).
        wr_base = wr_cnt;
        select = 1'b1; step(); select = 1'b0;
        check("src_rd_noerr", 64'(error), 64'd0);
        check("src_rd_nogen", 64'(genReq), 64'd0);
        step();
        check("genreq_2cyc", 64'(genReq), 64'd1);
        check("gensq", 64'(genSq), 64'd52);
        check("srcvalid_set", 64'(srcValid), 64'd1);
        check("srcsq_set", 64'(srcSq), 64'd52);
        genDone = 1'b1; genMask = (64'd1 << 36) | (64'd1 << 44);
        step();
        genDone = 1'b0; genMask = '0;
        check("genreq_drop", 64'(genReq), 64'd0);
        press(3, 1);
        select = 1'b1; step(); select = 1'b0;
        check("rd_dst_we0", 64'(brdWe), 64'd0);
        check("rd_dst_addr", 64'(brdAddr), 64'd44);
        step();
        check("rd_dst2_we0", 64'(brdWe), 64'd0);
        step();
        check("wr_dst_we", 64'(brdWe), 64'd1);
        check("wr_dst_addr", 64'(brdAddr), 64'd44);
        check("wr_dst_data", 64'(brdWdata), 64'h05);
        check("capture_empty", 64'(capture), 64'd0);
        check("wr_dst_nodone", 64'(moveDone), 64'd0);
        step();
        check("wr_src_we", 64'(brdWe), 64'd1);
        check("wr_src_addr", 64'(brdAddr), 64'd52);
        check("wr_src_data", 64'(brdWdata), 64'd0);
        check("movedone_4cyc", 64'(moveDone), 64'd1);
        step();
        check("turn_black", 64'(turn), 64'd1);
        check("srcvalid_clr", 64'(srcValid), 64'd0);
        check("movedone_pulse", 64'(moveDone), 64'd0);
        check("mem44", 64'(mem[44]), 64'h05);
        check("mem52", 64'(mem[52]), 64'd0);
        check("two_writes", 64'(wr_cnt - wr_base), 64'd2);

        // Generator timeout: black pawn on (1,4); genDone is never returned.
        press(3, 4);
        wr_base = wr_cnt;
        select = 1'b1; step(); select = 1'b0;
        step();
        check("tmo_genreq", 64'(genReq), 64'd1);
        err_base = err_cnt;
        for (int i = 1; i < 255; i++) step();
        check("tmo_quiet", 64'(err_cnt - err_base), 64'd0);
        check("tmo_err", 64'(error), 64'd1);
        step();
        check("tmo_srcvalid", 64'(srcValid), 64'd0);
        check("tmo_genreq_off", 64'(genReq), 64'd0);
        check("tmo_nowrite", 64'(wr_cnt - wr_base), 64'd0);

        // genDone in the final cycle counts as done. Then test a bad destination and a cancel.
        select = 1'b1; step(); select = 1'b0;
        step();
        for (int i = 1; i < 255; i++) step();
        genDone = 1'b1; genMask = 64'd1 << 20;
        #1;
        check("late_done_noerr", 64'(error), 64'd0);
        step();
        genDone = 1'b0; genMask = '0;
        check("late_done_pickdst", 64'(srcValid), 64'd1);
        check("late_done_genreq", 64'(genReq), 64'd0);
        press(2, 2);
        select = 1'b1;
        #1;
        check("bad_dst_err", 64'(error), 64'd1);
        step(); select = 1'b0;
        step();
        check("bad_dst_held", 64'(srcValid), 64'd1);
        press(3, 2);
        select = 1'b1;
        #1;
        check("cancel_noerr", 64'(error), 64'd0);
        step(); select = 1'b0;
        check("cancel_srcvalid", 64'(srcValid), 64'd0);
        check("cancel_turn", 64'(turn), 64'd1);
        step();

        // Black pawn (1,4) -> (2,4), which gives the turn back to white.
        select = 1'b1; step(); select = 1'b0;
        step();
        genDone = 1'b1; genMask = 64'd1 << 20;
        step();
        genDone = 1'b0; genMask = '0;
        press(2, 1);
        select = 1'b1; step(); select = 1'b0;
        step(); step(); step();
        check("black_move_done", 64'(moveDone), 64'd1);
        step();
        check("turn_white", 64'(turn), 64'd0);
        check("mem20", 64'(mem[20]), 64'h07);

        // Promotion: a white pawn on (1,0) captures the rook on (0,0).
        mem[8] = 5'b00101;
        press(3, 1);
        press(1, 4);
        select = 1'b1; step(); select = 1'b0;
        step();
        check("promo_gensq", 64'(genSq), 64'd8);
        genDone = 1'b1; genMask = 64'd1;
        step();
        genDone = 1'b0; genMask = '0;
        press(3, 1);
        select = 1'b1; step(); select = 1'b0;
        step(); step();
        check("promo_addr", 64'(brdAddr), 64'd0);
        check("promo_data", 64'(brdWdata), 64'(promo_exp));
        check("promo_capture", 64'(capture), 64'h13);
        step();
        check("promo_src_addr", 64'(brdAddr), 64'd8);
        step();
        check("promo_mem0", 64'(mem[0]), 64'(promo_exp));
        check("promo_turn", 64'(turn), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
